// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, multiple requests in flight,
// in-order response buffering and redirect flush with stale-response discard.
module riscv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       Reset,
    output logic                       IMemReqValid,
    input  logic                       IMemReqReady,
    output logic [XLEN-1:0]            IMemReqAddr,
    input  logic                       IMemRspValid,
    input  logic [31:0]                IMemRspData,
    input  logic                       Redirect,
    input  logic [XLEN-1:0]            RedirectPC,
    output logic                       InstrValid,
    input  logic                       InstrReady,
    output logic [31:0]                InstrF,
    output logic [XLEN-1:0]            PCF,
    output logic [XLEN-1:0]            PCPlus4F,
    output logic [$clog2(DEPTH+1)-1:0] QueueCount
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, pending, discard;
    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [CW:0]     committed;
    logic            accept, rsp_drop, push, pop, not_empty;

    // Slots already promised: queued words plus in-flight words that will be kept.
    assign committed = {1'b0, count} + {1'b0, pending} - {1'b0, discard};

    assign IMemReqValid = !Reset && !Redirect
                        && ({1'b0, pending} < DEPTH_W) && (committed < DEPTH_W);
    assign IMemReqAddr  = fetch_pc;

    assign accept    = IMemReqValid && IMemReqReady;
    assign rsp_drop  = (discard != '0);
    assign push      = IMemRspValid && !rsp_drop && !Redirect && !Reset;
    assign not_empty = (count != '0);
    assign pop       = InstrValid && InstrReady;

    assign InstrValid = !Reset && not_empty;
    assign InstrF     = not_empty ? instr_mem[rd_ptr] : NOP;
    assign PCF        = not_empty ? pc_mem[rd_ptr] : '0;
    assign PCPlus4F   = PCF + STEP;
    assign QueueCount = count;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            pending  <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            pending <= pending + CW'(accept) - CW'(IMemRspValid);
            if (Redirect) begin
                // Everything still outstanding after this cycle belongs to the old path.
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= RedirectPC;
                rsp_pc   <= RedirectPC;
                discard  <= pending - CW'(IMemRspValid);
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + STEP;
                if (IMemRspValid && rsp_drop)
                    discard <= discard - CW'(1);
                if (push) begin
                    rsp_pc <= rsp_pc + STEP;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr] <= IMemRspData;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: reference memory with epochs, expected-instruction queue,
// per-cycle model checks plus directed redirect/reset sequences and a redirect table.
module tb_riscv_fetch_queue;
    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        IMemReqValid;
    logic        IMemReqReady = 1'b1;
    logic [31:0] IMemReqAddr;
    logic        IMemRspValid = 1'b0;
    logic [31:0] IMemRspData = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        InstrValid;
    logic        InstrReady = 1'b1;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [2:0]  QueueCount;

    riscv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .Reset(Reset),
        .IMemReqValid(IMemReqValid), .IMemReqReady(IMemReqReady), .IMemReqAddr(IMemReqAddr),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrF(InstrF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .QueueCount(QueueCount)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] pc; int lat; logic [31:0] exp_pc; logic [31:0] exp_instr; logic [31:0] exp_pc4; } vec_t;

    req_t        mq[$];
    exp_t        sb[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, epoch = 0, lat = 1;
    int          drops = 0, n_pop = 0, n_acc = 0;
    bit          mon_en = 0, mem_rand = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] last_acc_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        Redirect = 1'b1;
        RedirectPC = pc;
        tick();
        Redirect = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok, output bit saw);
        ok = 0;
        saw = 0;
        for (int i = 0; i < lim; i++) begin
            if (InstrValid) begin
                ok = 1;
                break;
            end
            if (QueueCount != 0) saw = 1;
            tick();
        end
    endtask

    // Reference memory and per-cycle model checks; events apply at the following rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                int   fresh;
                bit   acc, pop;
                req_t r;
                exp_t e;
                IMemReqReady = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!Reset && mq.size() != 0 && mq[0].due <= cyc) begin
                    IMemRspValid = 1'b1;
                    IMemRspData  = mem_word(mq[0].addr);
                end else begin
                    IMemRspValid = 1'b0;
                    IMemRspData  = $urandom;
                end
                fresh = 0;
                foreach (mq[i]) if (mq[i].epoch == epoch) fresh++;
                chk("queue_count", 32'(QueueCount), 32'(sb.size()));
                chk("instr_valid", 32'(InstrValid), 32'(!Reset && sb.size() != 0));
                chk("req_valid", 32'(IMemReqValid),
                    32'(!Reset && !Redirect && mq.size() < DEPTH && sb.size() + fresh < DEPTH));
                chk("pending_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
                if (sb.size() != 0) begin
                    chk("head_instr", InstrF, sb[0].instr);
                    chk("head_pc", PCF, sb[0].pc);
                    chk("head_pc4", PCPlus4F, sb[0].pc + 32'd4);
                end else begin
                    chk("empty_instr", InstrF, NOP);
                    chk("empty_pc", PCF, 32'd0);
                    chk("empty_pc4", PCPlus4F, 32'd4);
                end
                acc = IMemReqValid && IMemReqReady;
                pop = InstrValid && InstrReady;
                if (Reset) begin
                    mq.delete();
                    sb.delete();
                    exp_fetch = RST_PC;
                    epoch++;
                end else if (Redirect) begin
                    if (IMemRspValid) begin
                        r = mq.pop_front();
                        drops++;
                    end
                    sb.delete();
                    exp_fetch = RedirectPC;
                    epoch++;
                end else begin
                    if (pop) begin
                        chk("pop_nonempty", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) e = sb.pop_front();
                        n_pop++;
                    end
                    if (IMemRspValid) begin
                        r = mq.pop_front();
                        if (r.epoch == epoch) begin
                            chk("no_overflow", 32'(sb.size() < DEPTH), 32'd1);
                            sb.push_back('{instr: mem_word(r.addr), pc: r.addr});
                        end else begin
                            drops++;
                        end
                    end
                    if (acc) begin
                        chk("req_addr", IMemReqAddr, exp_fetch);
                        mq.push_back('{addr: IMemReqAddr, epoch: epoch, due: cyc + lat});
                        last_acc_addr = IMemReqAddr;
                        exp_fetch = exp_fetch + 32'd4;
                        n_acc++;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        vec_t vecs[3];
        bit   ok, saw;
        int   d0, p0, a0;
        vecs[0] = '{pc: 32'h0000_1000, lat: 1, exp_pc: 32'h0000_1000, exp_instr: 32'h5A5A_1003, exp_pc4: 32'h0000_1004};
        vecs[1] = '{pc: 32'hFFFF_FFFC, lat: 2, exp_pc: 32'hFFFF_FFFC, exp_instr: 32'hA5A5_FFFF, exp_pc4: 32'h0000_0000};
        vecs[2] = '{pc: 32'h0000_0040, lat: 3, exp_pc: 32'h0000_0040, exp_instr: 32'h5A5A_0043, exp_pc4: 32'h0000_0044};

        // Reset state
        repeat (3) tick();
        mon_en = 1;
        chk("rst_count", 32'(QueueCount), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_req_valid", 32'(IMemReqValid), 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_pc", PCF, 32'd0);
        tick();

        // 1: streaming, first instruction two cycles after the first accept
        Reset = 1'b0;
        tick();
        chk("t1_valid_t1", 32'(InstrValid), 32'd0);
        tick();
        chk("t1_valid_t2", 32'(InstrValid), 32'd1);
        chk("t1_pcf", PCF, 32'h0);
        chk("t1_pc4", PCPlus4F, 32'h4);
        chk("t1_instr", InstrF, 32'h5A5A_0003);
        p0 = n_pop;
        repeat (20) tick();
        chk("t1_throughput", 32'(n_pop - p0), 32'd20);

        // 2: decode stall saturates the queue
        InstrReady = 1'b0;
        repeat (10) tick();
        chk("t2_count_full", 32'(QueueCount), 32'd4);
        chk("t2_req_stopped", 32'(IMemReqValid), 32'd0);
        InstrReady = 1'b1;
        repeat (10) tick();

        // 3: redirect with three requests outstanding
        lat = 3;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 3) begin ok = 1; break; end
            tick();
        end
        chk("t3_three_pending", 32'(ok), 32'd1);
        d0 = drops;
        redirect(32'h100);
        wait_valid(40, ok, saw);
        chk("t3_valid_seen", 32'(ok), 32'd1);
        chk("t3_empty_between", 32'(saw), 32'd0);
        chk("t3_pcf", PCF, 32'h100);
        chk("t3_instr", InstrF, 32'h5A5A_0103);
        chk("t3_drops", 32'(drops - d0), 32'd3);

        // 4: redirect coinciding with a response and a pop
        lat = 2;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (InstrValid && mq.size() != 0 && mq[0].due <= cyc) begin ok = 1; break; end
            tick();
        end
        chk("t4_setup", 32'(ok), 32'd1);
        p0 = mq.size();
        redirect(32'h400);
        chk("t4_count", 32'(QueueCount), 32'd0);
        chk("t4_valid", 32'(InstrValid), 32'd0);
        chk("t4_discard", 32'(dut.discard), 32'(p0 - 1));
        wait_valid(40, ok, saw);
        chk("t4_pcf", PCF, 32'h400);

        // 5: back-to-back redirects
        lat = 3;
        repeat (3) tick();
        redirect(32'h200);
        redirect(32'h300);
        wait_valid(40, ok, saw);
        chk("t5_valid_seen", 32'(ok), 32'd1);
        chk("t5_pcf", PCF, 32'h300);
        chk("t5_instr", InstrF, 32'h5A5A_0303);

        // 6: reset mid-stream with three entries queued
        lat = 1;
        InstrReady = 1'b0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (QueueCount == 3) begin ok = 1; break; end
            tick();
        end
        chk("t6_count3", 32'(ok), 32'd1);
        Reset = 1'b1;
        tick();
        chk("t6_valid", 32'(InstrValid), 32'd0);
        chk("t6_instr", InstrF, NOP);
        chk("t6_pcf", PCF, 32'd0);
        chk("t6_count", 32'(QueueCount), 32'd0);
        Reset = 1'b0;
        InstrReady = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            if (n_acc != a0) break;
            tick();
        end
        chk("t6_accepted", 32'(n_acc != a0), 32'd1);
        chk("t6_first_addr", last_acc_addr, RST_PC);

        // Redirect table, including PC wrap-around
        for (int v = 0; v < 3; v++) begin
            lat = vecs[v].lat;
            repeat (5) tick();
            redirect(vecs[v].pc);
            wait_valid(50, ok, saw);
            chk("tbl_valid", 32'(ok), 32'd1);
            chk("tbl_pcf", PCF, vecs[v].exp_pc);
            chk("tbl_instr", InstrF, vecs[v].exp_instr);
            chk("tbl_pc4", PCPlus4F, vecs[v].exp_pc4);
            repeat (6) tick();
        end

        // Randomised backpressure, latency and redirects
        mem_rand = 1;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            InstrReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) redirect({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            else tick();
        end
        mem_rand = 0;
        InstrReady = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
